// File: rtl/regfile_seq_if.sv
// Register-file bus between the test sequencer and the register file.
//   addr  : register-file address (0..7)
//   write : write strobe
//   read  : read strobe
//   in    : write data
//   out   : read data, valid exactly one cycle after read is high
// master modport: sequencer side; slave modport: register-file side.
interface regfile_seq_if;
  logic [2:0] addr;
  logic       write;
  logic       read;
  logic [3:0] in;
  logic [3:0] out;

  modport master (output addr, write, read, in, input out);
  modport slave  (input addr, write, read, in, output out);
endinterface

// File: rtl/regfile_seq.sv
// regfile_seq: self-test sequencer for an 8x4 register file.
// Writes a seed-based pattern to all 8 words, reads them back and compares
// each read one cycle later, then reports pass / error count / first
// failing address.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : request a run (sampled only in IDLE)
//   seed[3:0]      : pattern base, latched when start is accepted
//   rf             : register-file bus (regfile_seq_if.master)
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse at the end of a run
//   pass           : result of last run, held until next start
//   err_cnt[3:0]   : mismatch count of last run, saturating at 15
//   fail_addr[2:0] : address of first mismatch of last run (0 if none)
// Optional feature macro: REGFILE_SEQ_INVERT_PASS_EN adds a second
// write/read/drain pass using inverted data (states WRI, RDI, DRAINI).
module regfile_seq (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           seed,
  regfile_seq_if.master        rf,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [3:0]           err_cnt,
  output logic [2:0]           fail_addr
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, DRAIN, DONE
`ifdef REGFILE_SEQ_INVERT_PASS_EN
    , WRI, RDI, DRAINI
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] seed_q, seed_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fail_q, fail_d;
  // Compare slot for a read issued in the previous cycle.
  logic       pend_q, pend_d;
  logic [2:0] pend_addr_q, pend_addr_d;
  logic       pend_inv_q, pend_inv_d;

  logic [3:0] exp_data;
  logic [3:0] wr_data;
  logic       write_s;
  logic       read_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seed_q      <= '0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_inv_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_inv_q  <= pend_inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_d      = fail_q;
    pend_d      = 1'b0;
    pend_addr_d = cnt_q;
    pend_inv_d  = 1'b0;
    write_s     = 1'b0;
    read_s      = 1'b0;

    exp_data = seed_q + {1'b0, pend_addr_q};
    if (pend_inv_q) exp_data = ~exp_data;
    wr_data = seed_q + {1'b0, cnt_q};

    // Checked ahead of the state case so the compare slot is honoured in
    // whichever state follows a read (RD, DRAIN, RDI, DRAINI).
    if (pend_q && (rf.out != exp_data)) begin
      if (err_q != 4'hF) err_d = err_q + 4'd1;
      if (err_q == 4'd0) fail_d = pend_addr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR;
          cnt_d   = '0;
          seed_d  = seed;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      WR: begin
        write_s = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = RD;
      end
      RD: begin
        read_s = 1'b1;
        pend_d = 1'b1;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DRAIN;
      end
      DRAIN: begin
`ifdef REGFILE_SEQ_INVERT_PASS_EN
        state_d = WRI;
`else
        state_d = DONE;
`endif
      end
`ifdef REGFILE_SEQ_INVERT_PASS_EN
      WRI: begin
        write_s = 1'b1;
        wr_data = ~wr_data;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = RDI;
      end
      RDI: begin
        read_s     = 1'b1;
        pend_d     = 1'b1;
        pend_inv_d = 1'b1;
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DRAINI;
      end
      DRAINI: begin
        state_d = DONE;
      end
`endif
      DONE: begin
        pass_d  = (err_q == 4'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf.addr   = cnt_q;
  assign rf.write  = write_s;
  assign rf.read   = read_s;
  assign rf.in     = write_s ? wr_data : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: stimulus pushes expected writes and
// run results into queues; a negedge monitor pops and compares them.
module tb_regfile_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] seed = '0;
  logic       busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_addr;

  regfile_seq_if rf ();

  regfile_seq dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .rf(rf),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_SEQ_INVERT_PASS_EN
  localparam int DONE_CYC = 35;
  localparam int E_FORCE  = 3;   // addr4 mismatches twice, addr6 only on the plain pass
  localparam int E_ZERO   = 15;  // 16 mismatches, saturated
  localparam int M7_S6    = 2;   // ~13
  localparam int M3_S13   = 15;  // ~0
`else
  localparam int DONE_CYC = 18;
  localparam int E_FORCE  = 2;
  localparam int E_ZERO   = 8;
  localparam int M7_S6    = 13;
  localparam int M3_S13   = 0;
`endif

  // Register file model: registered read, optional fault modes.
  logic [3:0] mem [8];
  int mode = 0;  // 0 ideal, 1 addr4->15 & addr6->0, 2 always 0
  always @(posedge clk) begin
    if (rf.write) mem[rf.addr] <= rf.in;
    if (rf.read) begin
      if (mode == 2) rf.out <= 4'd0;
      else if (mode == 1 && rf.addr == 3'd4) rf.out <= 4'd15;
      else if (mode == 1 && rf.addr == 3'd6) rf.out <= 4'd0;
      else rf.out <= mem[rf.addr];
    end
  end

  typedef struct {
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic [2:0] fail;
  } run_t;

  run_t       runq [$];
  logic [6:0] wrq  [$];  // {addr, data}
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_run(input logic [3:0] s, input logic ep,
                          input logic [3:0] ee, input logic [2:0] ef);
    run_t r;
    logic [3:0] d;
    r.cyc = DONE_CYC; r.pass = ep; r.err = ee; r.fail = ef;
    runq.push_back(r);
    for (int unsigned a = 0; a < 8; a++) begin
      d = s + 4'(a);
      wrq.push_back({3'(a), d});
    end
`ifdef REGFILE_SEQ_INVERT_PASS_EN
    for (int unsigned a = 0; a < 8; a++) begin
      d = ~(s + 4'(a));
      wrq.push_back({3'(a), d});
    end
`endif
  endtask

  task automatic wait_runs;
    int n = 0;
    while (runq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("run_completed", runq.size(), 0);
    runq.delete();
    wrq.delete();
  endtask

  task automatic run(input logic [3:0] s, input int m, input logic ep,
                     input logic [3:0] ee, input logic [2:0] ef);
    mode = m;
    push_run(s, ep, ee, ef);
    @(posedge clk) #1;
    start = 1'b1; seed = s;
    @(posedge clk) #1;
    start = 1'b0;
    wait_runs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fail"}, fail_addr, 0);
    check({tag, "_addr"}, rf.addr, 0);
    check({tag, "_write"}, rf.write, 0);
    check({tag, "_read"}, rf.read, 0);
    check({tag, "_in"}, rf.in, 0);
  endtask

  // Monitor
  initial begin
    int   cyc;
    logic prev_busy;
    logic pass_due;
    logic exp_pass;
    run_t r;
    logic [6:0] w;
    cyc = 0; prev_busy = 1'b0; pass_due = 1'b0; exp_pass = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; prev_busy = 1'b0; pass_due = 1'b0;
      end else begin
        if (pass_due) begin
          check("pass", pass, exp_pass);
          pass_due = 1'b0;
        end
        if (busy) cyc = prev_busy ? cyc + 1 : 1;
        prev_busy = busy;
        if (rf.write) begin
          check("rw_exclusive", rf.read, 0);
          if (wrq.size() == 0) check("unexpected_write", 1, 0);
          else begin
            w = wrq.pop_front();
            check("waddr", rf.addr, w[6:4]);
            check("wdata", rf.in, w[3:0]);
          end
        end
        if (done) begin
          if (runq.size() == 0) check("unexpected_done", 1, 0);
          else begin
            r = runq.pop_front();
            check("done_cycle", cyc, r.cyc);
            check("err_cnt", err_cnt, r.err);
            check("fail_addr", fail_addr, r.fail);
            exp_pass = r.pass;
            pass_due = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic found;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    // rst wins over start
    start = 1'b1; seed = 4'd6;
    @(posedge clk) #1;
    check("rst_over_start_busy", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run(4'd6, 0, 1'b1, 4'd0, 3'd0);
    check("mem7_seed6", mem[7], M7_S6);
    run(4'd13, 0, 1'b1, 4'd0, 3'd0);
    check("mem3_seed13_wrap", mem[3], M3_S13);
    run(4'd9, 1, 1'b0, 4'(E_FORCE), 3'd4);
    run(4'd1, 2, 1'b0, 4'(E_ZERO), 3'd0);

    // reset during RD at address 5
    mode = 0;
    push_run(4'd6, 1'b1, 4'd0, 3'd0);
    @(posedge clk) #1;
    start = 1'b1; seed = 4'd6;
    @(posedge clk) #1;
    start = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (rf.read && rf.addr == 3'd5) found = 1'b1;
      n++;
    end
    check("reached_rd_addr5", found, 1);
    rst = 1'b1;
    @(posedge clk) #1;
    check_reset_outputs("midrun_reset");
    runq.delete();
    wrq.delete();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run(4'd6, 0, 1'b1, 4'd0, 3'd0);

    // start held high: one run per IDLE visit, two runs expected
    mode = 0;
    push_run(4'd5, 1'b1, 4'd0, 3'd0);
    push_run(4'd5, 1'b1, 4'd0, 3'd0);
    @(posedge clk) #1;
    start = 1'b1; seed = 4'd5;
    wait_runs();
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_extra_run_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
